// File: rtl/clk_div_seg_pkg.sv
// rtl/clk_div_seg_pkg.sv - shared constants for clk_div_seg_driver (segment codes, FSM encodings)
package clk_div_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off in the table
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAZARD = 2'b01,
    TURN   = 2'b10
  } fsm_state_t;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - 50% duty clock divider with registered rising-edge pulse
module tick_divider #(
  parameter int HALF_PERIOD = 1,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out,
  output logic rise_pulse
);

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $error("tick_divider: HALF_PERIOD must be >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // rise_pulse is set on the same edge that drives clk_out high, so both are registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      rise_pulse <= 1'b0;
    end else if (cnt == TERM) begin
      cnt        <= '0;
      clk_out    <= ~clk_out;
      rise_pulse <= ~clk_out;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      rise_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_seg_driver.sv
// rtl/clk_div_seg_driver.sv - system/memory clock dividers plus hex segment decoder; CLKDIV_SEG_HEARTBEAT_EN blinks dp
module clk_div_seg_driver
  import clk_div_seg_pkg::*;
#(
  parameter int SYS_HALF_PERIOD = 5_000_000,
  parameter int MEM_HALF_PERIOD = 2_500_000,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num_in,
  output logic       sys_clk_out,
  output logic       mem_clk_out,
  output logic       sys_tick,
  output logic [7:0] hex_out
);

  logic unused_mem_rise;
  logic dp;

  tick_divider #(
    .HALF_PERIOD(SYS_HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_sys_div (
    .clk       (clk),
    .reset     (reset),
    .clk_out   (sys_clk_out),
    .rise_pulse(sys_tick)
  );

  tick_divider #(
    .HALF_PERIOD(MEM_HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_mem_div (
    .clk       (clk),
    .reset     (reset),
    .clk_out   (mem_clk_out),
    .rise_pulse(unused_mem_rise)
  );

`ifdef CLKDIV_SEG_HEARTBEAT_EN
  assign dp = ~sys_clk_out;
`else
  assign dp = 1'b1;
`endif

  // Unknown num_in matches no item and falls to blank
  always_comb begin
    hex_out = SEG_BLANK;
    case (num_in)
      4'h0: hex_out = {dp, SEG_LUT[0][6:0]};
      4'h1: hex_out = {dp, SEG_LUT[1][6:0]};
      4'h2: hex_out = {dp, SEG_LUT[2][6:0]};
      4'h3: hex_out = {dp, SEG_LUT[3][6:0]};
      4'h4: hex_out = {dp, SEG_LUT[4][6:0]};
      4'h5: hex_out = {dp, SEG_LUT[5][6:0]};
      4'h6: hex_out = {dp, SEG_LUT[6][6:0]};
      4'h7: hex_out = {dp, SEG_LUT[7][6:0]};
      4'h8: hex_out = {dp, SEG_LUT[8][6:0]};
      4'h9: hex_out = {dp, SEG_LUT[9][6:0]};
      4'hA: hex_out = {dp, SEG_LUT[10][6:0]};
      4'hB: hex_out = {dp, SEG_LUT[11][6:0]};
      4'hC: hex_out = {dp, SEG_LUT[12][6:0]};
      4'hD: hex_out = {dp, SEG_LUT[13][6:0]};
      4'hE: hex_out = {dp, SEG_LUT[14][6:0]};
      4'hF: hex_out = {dp, SEG_LUT[15][6:0]};
      default: hex_out = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_clk_div_seg_driver.sv
// tb/tb_clk_div_seg_driver.sv - directed self-checking bench for clk_div_seg_driver
module tb_clk_div_seg_driver;

  logic       clk;
  logic       reset;
  logic [3:0] num_in;
  logic       sys_clk_out, mem_clk_out, sys_tick;
  logic [7:0] hex_out;

  logic [3:0] num_in1;
  logic       sys1, mem1, tick1;
  logic [7:0] hex1;

  int tests_run;
  int tests_failed;

  clk_div_seg_driver #(
    .SYS_HALF_PERIOD(3),
    .MEM_HALF_PERIOD(5),
    .CNT_W          (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .num_in     (num_in),
    .sys_clk_out(sys_clk_out),
    .mem_clk_out(mem_clk_out),
    .sys_tick   (sys_tick),
    .hex_out    (hex_out)
  );

  clk_div_seg_driver #(
    .SYS_HALF_PERIOD(1),
    .MEM_HALF_PERIOD(1),
    .CNT_W          (8)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .num_in     (num_in1),
    .sys_clk_out(sys1),
    .mem_clk_out(mem1),
    .sys_tick   (tick1),
    .hex_out    (hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seg_exp [16];
  initial begin
    seg_exp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (sys_clk_out !== 1'b0 || mem_clk_out !== 1'b0 || sys_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: sys=%b mem=%b tick=%b, required 0 0 0", sys_clk_out, mem_clk_out, sys_tick);
    end
    tests_run++;
    if (sys1 !== 1'b0 || tick1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_h1: sys=%b tick=%b, required 0 0", sys1, tick1);
    end
  endtask

  // Sweep while reset is held: sys_clk_out=0, so dp is off with or without heartbeat
  task automatic test_seg_sweep();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      num_in = 4'(i);
      #1;
      exp = seg_exp[i];
      tests_run++;
      if (hex_out !== exp) begin
        tests_failed++;
        $display("FAIL seg_%0h: hex_out=%h, required %h", i, hex_out, exp);
      end
    end
    num_in = {2'b00, 2'b01};
    #1;
    tests_run++;
    if (hex_out !== 8'hF9) begin
      tests_failed++;
      $display("FAIL seg_hazard: hex_out=%h, required F9", hex_out);
    end
  endtask

  // Releases reset then follows 18 cycles; cycle c = number of edges since release
  task automatic test_dividers();
    logic exp_sys, exp_mem, exp_tick, exp_h1;
    logic [7:0] exp_hex;
    num_in = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_sys  = ((c / 3) % 2) == 1;
      exp_mem  = ((c / 5) % 2) == 1;
      exp_tick = (c % 6) == 3;
      exp_h1   = (c % 2) == 1;
`ifdef CLKDIV_SEG_HEARTBEAT_EN
      exp_hex  = exp_sys ? 8'h40 : 8'hC0;
`else
      exp_hex  = 8'hC0;
`endif
      tests_run++;
      if (sys_clk_out !== exp_sys) begin
        tests_failed++;
        $display("FAIL sys_clk_c%0d: got %b, required %b", c, sys_clk_out, exp_sys);
      end
      tests_run++;
      if (mem_clk_out !== exp_mem) begin
        tests_failed++;
        $display("FAIL mem_clk_c%0d: got %b, required %b", c, mem_clk_out, exp_mem);
      end
      tests_run++;
      if (sys_tick !== exp_tick) begin
        tests_failed++;
        $display("FAIL sys_tick_c%0d: got %b, required %b", c, sys_tick, exp_tick);
      end
      tests_run++;
      if (sys1 !== exp_h1 || tick1 !== exp_h1) begin
        tests_failed++;
        $display("FAIL half1_c%0d: sys=%b tick=%b, required %b", c, sys1, tick1, exp_h1);
      end
      tests_run++;
      if (hex_out !== exp_hex) begin
        tests_failed++;
        $display("FAIL heartbeat_c%0d: hex_out=%h, required %h", c, hex_out, exp_hex);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int rise_at;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (sys_clk_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre: sys_clk_out=%b, required 1", sys_clk_out);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (sys_clk_out !== 1'b0 || sys_tick !== 1'b0 || mem_clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: sys=%b tick=%b mem=%b, required 0 0 0", sys_clk_out, sys_tick, mem_clk_out);
    end
    reset = 1'b0;
    rise_at = -1;
    for (int c = 1; c <= 20 && rise_at < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (sys_tick === 1'b1 && sys_clk_out === 1'b1) rise_at = c;
    end
    tests_run++;
    if (rise_at != 3) begin
      tests_failed++;
      $display("FAIL mid_rerise: rise after %0d cycles (-1 = none within 20), required 3", rise_at);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    num_in       = 4'h0;
    num_in1      = 4'h0;
    test_reset();
    test_seg_sweep();
    test_dividers();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
